icache_refill_ctrl: RTL and testbench



---
 rtl/icache_refill_ctrl.sv | 166 ++++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill_ctrl
// Description : Miss-handling controller for the L1 instruction cache.
//               It latches a line-aligned miss address and issues one line
//               request to the lower memory level. It assembles NBEATS
//               response beats into a line and writes that line into the
//               cache. Fetch stays stalled until the line can be re-read.
// Ports       : clk, reset           - clock, synchronous active-high reset
//               miss_i, missAddr_i   - cache miss and its address
//               memReq*              - line request (valid/ready handshake)
//               memResp*             - response beats (no backpressure)
//               wrEnable_o, wrAddr_o,
//               instBlock_o          - one-cycle line write into the cache
//               fetchStall_o         - fetch must hold its PC
//               busy_o               - a refill is in progress
//               refillCount_o        - completed refills (wraps at 2^16)
//               protocolErr_o        - sticky: beat seen outside WAIT
// Revision    : 1.0 - initial release
// ============================================================================
module icache_refill_ctrl #(
    parameter int SIZE_PC     = 32,
    parameter int CACHE_WIDTH = 256,
    parameter int BEAT_WIDTH  = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   miss_i,
    input  logic [SIZE_PC-1:0]     missAddr_i,
    output logic                   memReqValid_o,
    output logic [SIZE_PC-1:0]     memReqAddr_o,
    input  logic                   memReqReady_i,
    input  logic                   memRespValid_i,
    input  logic [BEAT_WIDTH-1:0]  memRespData_i,
    output logic                   wrEnable_o,
    output logic [SIZE_PC-1:0]     wrAddr_o,
    output logic [CACHE_WIDTH-1:0] instBlock_o,
    output logic                   fetchStall_o,
    output logic                   busy_o,
    output logic [15:0]            refillCount_o,
    output logic                   protocolErr_o
);

    localparam int NBEATS      = CACHE_WIDTH / BEAT_WIDTH;
    localparam int OFFSET_BITS = $clog2(CACHE_WIDTH / 8);
    localparam int BEAT_CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(NBEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_FILL   = 3'd3,
        S_REPLAY = 3'd4
    } state_t;

    state_t                 state_q,      state_d;
    logic [SIZE_PC-1:0]     line_addr_q,  line_addr_d;
    logic [CACHE_WIDTH-1:0] line_buf_q,   line_buf_d;
    logic [BEAT_CNT_W-1:0]  beat_cnt_q,   beat_cnt_d;
    logic                   req_valid_q,  req_valid_d;
    logic                   wr_en_q,      wr_en_d;
    logic                   busy_q,       busy_d;
    logic                   proto_err_q,  proto_err_d;
    logic [15:0]            refill_cnt_q, refill_cnt_d;

    // Offset bits of the miss address are dropped by line alignment.
    logic w_unused_offset;
    assign w_unused_offset = ^missAddr_i[OFFSET_BITS-1:0];

    always_comb begin
        state_d      = state_q;
        line_addr_d  = line_addr_q;
        line_buf_d   = line_buf_q;
        beat_cnt_d   = beat_cnt_q;
        refill_cnt_d = refill_cnt_q;
        proto_err_d  = proto_err_q;

        case (state_q)
            S_IDLE: begin
                if (miss_i) begin
                    line_addr_d = {missAddr_i[SIZE_PC-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                    beat_cnt_d  = '0;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                if (memReqReady_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (memRespValid_i) begin
                    for (int k = 0; k < NBEATS; k++) begin
                        if (beat_cnt_q == BEAT_CNT_W'(k)) begin
                            line_buf_d[k*BEAT_WIDTH +: BEAT_WIDTH] = memRespData_i;
                        end
                    end
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                refill_cnt_d = refill_cnt_q + 16'd1;
                state_d      = S_REPLAY;
            end
            S_REPLAY: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Beats are only legal while collecting; anything else is dropped
        // and flagged until reset.
        if (memRespValid_i && (state_q != S_WAIT)) begin
            proto_err_d = 1'b1;
        end

        // Outputs are registered by decoding the next state.
        req_valid_d = (state_d == S_REQ);
        wr_en_d     = (state_d == S_FILL);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            line_addr_q  <= '0;
            line_buf_q   <= '0;
            beat_cnt_q   <= '0;
            req_valid_q  <= 1'b0;
            wr_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            proto_err_q  <= 1'b0;
            refill_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            line_addr_q  <= line_addr_d;
            line_buf_q   <= line_buf_d;
            beat_cnt_q   <= beat_cnt_d;
            req_valid_q  <= req_valid_d;
            wr_en_q      <= wr_en_d;
            busy_q       <= busy_d;
            proto_err_q  <= proto_err_d;
            refill_cnt_q <= refill_cnt_d;
        end
    end

    assign memReqValid_o = req_valid_q;
    assign memReqAddr_o  = line_addr_q;
    assign wrEnable_o    = wr_en_q;
    assign wrAddr_o      = line_addr_q;
    assign instBlock_o   = line_buf_q;
    assign busy_o        = busy_q;
    assign refillCount_o = refill_cnt_q;
    assign protocolErr_o = proto_err_q;

    // The idle term is combinational so fetch stalls on the first miss cycle.
    assign fetchStall_o  = ((state_q == S_IDLE) && miss_i) || busy_q;

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_refill_ctrl
// Description : Self-checking bench for icache_refill_ctrl. A behavioural
//               model tracks each refill as a transaction: the request,
//               a queue of collected beats, the write, and the replay. It
//               is compared against the DUT every cycle. Directed scenarios
//               add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_refill_ctrl;

    logic         clk;
    logic         reset;
    logic         miss_i;
    logic [31:0]  missAddr_i;
    logic         memReqValid_o;
    logic [31:0]  memReqAddr_o;
    logic         memReqReady_i;
    logic         memRespValid_i;
    logic [63:0]  memRespData_i;
    logic         wrEnable_o;
    logic [31:0]  wrAddr_o;
    logic [255:0] instBlock_o;
    logic         fetchStall_o;
    logic         busy_o;
    logic [15:0]  refillCount_o;
    logic         protocolErr_o;

    int n_vec = 0;
    int n_bad = 0;
    logic preload = 1'b0;

    icache_refill_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .miss_i         (miss_i),
        .missAddr_i     (missAddr_i),
        .memReqValid_o  (memReqValid_o),
        .memReqAddr_o   (memReqAddr_o),
        .memReqReady_i  (memReqReady_i),
        .memRespValid_i (memRespValid_i),
        .memRespData_i  (memRespData_i),
        .wrEnable_o     (wrEnable_o),
        .wrAddr_o       (wrAddr_o),
        .instBlock_o    (instBlock_o),
        .fetchStall_o   (fetchStall_o),
        .busy_o         (busy_o),
        .refillCount_o  (refillCount_o),
        .protocolErr_o  (protocolErr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_live = 1'b0;
    logic        m_req, m_collect, m_fill, m_replay, m_err;
    logic [31:0] m_addr;
    logic [15:0] m_cnt;
    logic [63:0] m_beats[$];

    always @(posedge clk) begin
        if (reset) begin
            m_live = 1'b1; m_req = 1'b0; m_collect = 1'b0; m_fill = 1'b0;
            m_replay = 1'b0; m_err = 1'b0; m_addr = '0; m_cnt = '0;
            m_beats.delete();
        end else if (m_live) begin
            if (memRespValid_i && !m_collect) m_err = 1'b1;
            if (preload) m_cnt = 16'hFFFF;
            if (m_replay) begin
                m_replay = 1'b0;
            end else if (m_fill) begin
                m_fill = 1'b0; m_replay = 1'b1; m_cnt = m_cnt + 16'd1;
                m_beats.delete();
            end else if (m_collect) begin
                if (memRespValid_i) m_beats.push_back(memRespData_i);
                if (m_beats.size() == 4) begin m_collect = 1'b0; m_fill = 1'b1; end
            end else if (m_req) begin
                if (memReqReady_i) begin m_req = 1'b0; m_collect = 1'b1; end
            end else if (miss_i) begin
                m_addr = missAddr_i & ~32'h1F;
                m_req  = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_live) begin
            logic         busy_e;
            logic [255:0] line_e;
            busy_e = m_req | m_collect | m_fill | m_replay;
            chk("memReqValid", memReqValid_o, m_req);
            chk("wrEnable", wrEnable_o, m_fill);
            chk("busy", busy_o, busy_e);
            chk("fetchStall", fetchStall_o, busy_e | miss_i);
            chk("protocolErr", protocolErr_o, m_err);
            if (m_req) chk("memReqAddr", memReqAddr_o, m_addr);
            if (m_fill) begin
                line_e = '0;
                for (int k = 0; k < m_beats.size(); k++) line_e[k*64 +: 64] = m_beats[k];
                chk("wrAddr", wrAddr_o, m_addr);
                chk("instBlock", instBlock_o, line_e);
            end
            if (!preload) chk("refillCount", refillCount_o, m_cnt);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic [63:0] beat(input int k, input logic [63:0] x);
        return (64'h1111_1111_1111_1111 * 64'(k + 1)) ^ x;
    endfunction

    // Starts in an IDLE cycle; returns at the start of the REPLAY cycle.
    task automatic run_refill(input logic [31:0] a, input int rdy_delay,
                              input int g0, input int g1, input int g2, input int g3,
                              input logic [63:0] x);
        int gaps[4];
        gaps = '{g0, g1, g2, g3};
        miss_i = 1'b1; missAddr_i = a;
        tick();
        miss_i = 1'b0; missAddr_i = a ^ 32'hDEAD_BEE0; memReqReady_i = 1'b0;
        for (int i = 0; i < rdy_delay; i++) tick();
        memReqReady_i = 1'b1;
        tick();
        memReqReady_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gaps[k]; g++) tick();
            memRespValid_i = 1'b1; memRespData_i = beat(k, x);
            tick();
            memRespValid_i = 1'b0; memRespData_i = '0;
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; miss_i = 1'b1; missAddr_i = '0; memReqReady_i = 1'b0;
        memRespValid_i = 1'b0; memRespData_i = '0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_stall", fetchStall_o, 1'b1);
        chk("rst_reqValid", memReqValid_o, 1'b0);
        chk("rst_cnt", refillCount_o, 16'h0);
        chk("rst_inst", instBlock_o, 256'h0);
        tick();
        reset = 1'b0; miss_i = 1'b0;

        // Basic refill, cycle-accurate literal checks
        miss_i = 1'b1; missAddr_i = 32'h0000_1234;           // cycle 0
        @(negedge clk); chk("t1_stall_c0", fetchStall_o, 1'b1);
        tick(); miss_i = 1'b0; memReqReady_i = 1'b1;          // cycle 1
        @(negedge clk);
        chk("t1_reqValid", memReqValid_o, 1'b1);
        chk("t1_reqAddr", memReqAddr_o, 32'h0000_1220);
        tick(); memReqReady_i = 1'b0;
        memRespValid_i = 1'b1; memRespData_i = 64'h1111_1111_1111_1111;
        tick(); memRespData_i = 64'h2222_2222_2222_2222;
        tick(); memRespData_i = 64'h3333_3333_3333_3333;
        tick(); memRespData_i = 64'h4444_4444_4444_4444;
        tick(); memRespValid_i = 1'b0; memRespData_i = '0;    // cycle 6
        @(negedge clk);
        chk("t1_wrEn", wrEnable_o, 1'b1);
        chk("t1_wrAddr", wrAddr_o, 32'h0000_1220);
        chk("t1_line", instBlock_o,
            256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
        tick();                                               // cycle 7
        @(negedge clk);
        chk("t1_stall_c7", fetchStall_o, 1'b1);
        chk("t1_cnt", refillCount_o, 16'd1);
        tick();                                               // cycle 8
        @(negedge clk); chk("t1_stall_c8", fetchStall_o, 1'b0);

        // Request backpressure
        run_refill(32'h0000_ABCD, 5, 0, 0, 0, 0, 64'h0F0F_0F0F_0F0F_0F0F);
        tick();
        @(negedge clk); chk("t2_cnt", refillCount_o, 16'd2);

        // Gapped response: beats at WAIT cycles 0,3,4,9
        run_refill(32'h8000_0047, 0, 0, 2, 0, 4, 64'hA5A5_0000_5A5A_FFFF);
        tick();
        @(negedge clk);
        chk("t3_err", protocolErr_o, 1'b0);
        chk("t3_cnt", refillCount_o, 16'd3);

        // Stray beat in IDLE
        memRespValid_i = 1'b1; memRespData_i = 64'hBAD0_BAD0_BAD0_BAD0;
        tick(); memRespValid_i = 1'b0; memRespData_i = '0;
        @(negedge clk); chk("t4_err_set", protocolErr_o, 1'b1);
        run_refill(32'h0000_2000, 1, 1, 0, 0, 0, 64'h0);
        tick();
        @(negedge clk);
        chk("t4_err_sticky", protocolErr_o, 1'b1);
        chk("t4_cnt", refillCount_o, 16'd4);

        // Reset mid-WAIT after two beats
        miss_i = 1'b1; missAddr_i = 32'h0000_3030;
        tick(); miss_i = 1'b0; memReqReady_i = 1'b1;
        tick(); memReqReady_i = 1'b0;
        memRespValid_i = 1'b1; memRespData_i = beat(0, 64'h77);
        tick(); memRespData_i = beat(1, 64'h77);
        tick(); memRespValid_i = 1'b0; memRespData_i = '0; reset = 1'b1;
        tick(); reset = 1'b0;
        @(negedge clk);
        chk("t5_busy", busy_o, 1'b0);
        chk("t5_wrEn", wrEnable_o, 1'b0);
        chk("t5_cnt", refillCount_o, 16'd0);
        tick();
        run_refill(32'h0000_3030, 0, 0, 0, 0, 0, 64'h1234_5678_9ABC_DEF0);
        tick();
        @(negedge clk); chk("t5_cnt_after", refillCount_o, 16'd1);

        // Back-to-back misses: second miss in the cycle after REPLAY
        run_refill(32'h0000_4000, 0, 0, 0, 0, 0, 64'h1);
        tick();
        run_refill(32'h0000_4000, 0, 0, 1, 0, 0, 64'h2);
        tick();
        @(negedge clk); chk("t6_cnt", refillCount_o, 16'd3);

        // Counter wrap: preload 0xFFFF then one more refill
        tick();
        preload = 1'b1;
        force dut.refill_cnt_q = 16'hFFFF;
        tick();
        release dut.refill_cnt_q;
        preload = 1'b0;
        @(negedge clk); chk("t7_preload", refillCount_o, 16'hFFFF);
        tick();
        run_refill(32'hFFFF_FFE0, 0, 0, 0, 0, 0, 64'h3);
        tick();
        @(negedge clk); chk("t7_wrap", refillCount_o, 16'h0000);

        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
